// File: rtl/mer_power_accum_pkg.sv
// rtl/mer_power_accum_pkg.sv - shared widths, window defaults and saturation limit for the MER power accumulator
package mer_power_accum_pkg;

    localparam int DATA_W       = 18;          // 1s17 slicer samples and output powers
    localparam int SQ_W         = 2 * DATA_W;  // width of a single square
    localparam int SUM_W        = SQ_W + 1;    // I^2 + Q^2 before the shift
    localparam int DEF_LOG2_LEN = 10;
    localparam int DEF_SQ_SHIFT = 20;

    localparam logic [DATA_W-1:0] PWR_MAX = 18'd131071;

    // Accumulator width large enough that a full window of shifted powers never wraps
    function automatic int acc_width(input int log2_len, input int sq_shift);
        return SUM_W - sq_shift + log2_len + 1;
    endfunction

endpackage

// File: rtl/mer_square_sum.sv
// rtl/mer_square_sum.sv - two-stage registered (I^2 + Q^2) >>> SQ_SHIFT with valid tag
module mer_square_sum
    import mer_power_accum_pkg::*;
#(
    parameter int SQ_SHIFT = DEF_SQ_SHIFT
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic signed [DATA_W-1:0] in_q,
    output logic signed [SUM_W-1:0]  p_out,
    output logic                     p_valid
);

    logic signed [SQ_W-1:0]  i_sq_q, i_sq_d;
    logic signed [SQ_W-1:0]  q_sq_q, q_sq_d;
    logic signed [SUM_W-1:0] p_q, p_d;
    logic                    v1_q, v1_d;
    logic                    v2_q, v2_d;

    // Squares and shifted sum advance every clock; clear only kills the valid tags
    always_comb begin
        i_sq_d = SQ_W'(in_i) * SQ_W'(in_i);
        q_sq_d = SQ_W'(in_q) * SQ_W'(in_q);
        p_d    = (SUM_W'(i_sq_q) + SUM_W'(q_sq_q)) >>> SQ_SHIFT;
        v1_d   = in_valid & ~clear;
        v2_d   = v1_q & ~clear;
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            i_sq_q <= '0;
            q_sq_q <= '0;
            p_q    <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            i_sq_q <= i_sq_d;
            q_sq_q <= q_sq_d;
            p_q    <= p_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
        end
    end

    assign p_out   = p_q;
    assign p_valid = v2_q;

endmodule

// File: rtl/mer_power_accum.sv
// rtl/mer_power_accum.sv - windowed decision/error power averager; MER_ACCUM_SAT_EN enables output saturation
module mer_power_accum
    import mer_power_accum_pkg::*;
#(
    parameter int LOG2_LEN = DEF_LOG2_LEN,
    parameter int SQ_SHIFT = DEF_SQ_SHIFT
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] decision_i,
    input  logic signed [DATA_W-1:0] decision_q,
    input  logic signed [DATA_W-1:0] error_i,
    input  logic signed [DATA_W-1:0] error_q,
    output logic signed [DATA_W-1:0] mapper_power,
    output logic signed [DATA_W-1:0] error_power,
    output logic                     power_valid
);

    localparam int AW = acc_width(LOG2_LEN, SQ_SHIFT);
`ifdef MER_ACCUM_SAT_EN
    localparam int AVG_W = (AW > DATA_W) ? AW : DATA_W;
`else
    localparam int AVG_W = DATA_W;
`endif

    logic signed [SUM_W-1:0]  p_dec, p_err;
    logic                     v2_dec, v2_err, v2;

    logic [AW-1:0]            acc_dec_q, acc_dec_d;
    logic [AW-1:0]            acc_err_q, acc_err_d;
    logic [LOG2_LEN-1:0]      cnt_q, cnt_d;
    logic signed [DATA_W-1:0] mapper_power_q, mapper_power_d;
    logic signed [DATA_W-1:0] error_power_q, error_power_d;
    logic                     power_valid_q, power_valid_d;

    logic [AW-1:0]            sum_dec, sum_err;
    logic [AVG_W-1:0]         avg_dec, avg_err;

    mer_square_sum #(.SQ_SHIFT(SQ_SHIFT)) u_sq_dec (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (clk_en),
        .in_i     (decision_i),
        .in_q     (decision_q),
        .p_out    (p_dec),
        .p_valid  (v2_dec)
    );

    mer_square_sum #(.SQ_SHIFT(SQ_SHIFT)) u_sq_err (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (clk_en),
        .in_i     (error_i),
        .in_q     (error_q),
        .p_out    (p_err),
        .p_valid  (v2_err)
    );

    // Both paths carry identical valid tags
    assign v2 = v2_dec & v2_err;

    // Accumulate; on the last symbol fold it into the average and restart the window on the same edge
    always_comb begin
        acc_dec_d      = acc_dec_q;
        acc_err_d      = acc_err_q;
        cnt_d          = cnt_q;
        mapper_power_d = mapper_power_q;
        error_power_d  = error_power_q;
        power_valid_d  = 1'b0;
        sum_dec        = acc_dec_q + AW'($unsigned(p_dec));
        sum_err        = acc_err_q + AW'($unsigned(p_err));
        avg_dec        = AVG_W'(sum_dec >> LOG2_LEN);
        avg_err        = AVG_W'(sum_err >> LOG2_LEN);

        if (clear) begin
            acc_dec_d = '0;
            acc_err_d = '0;
            cnt_d     = '0;
        end else if (v2) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                acc_dec_d     = '0;
                acc_err_d     = '0;
                power_valid_d = 1'b1;
`ifdef MER_ACCUM_SAT_EN
                mapper_power_d = (avg_dec > AVG_W'(PWR_MAX)) ? PWR_MAX : avg_dec[DATA_W-1:0];
                error_power_d  = (avg_err > AVG_W'(PWR_MAX)) ? PWR_MAX : avg_err[DATA_W-1:0];
`else
                mapper_power_d = avg_dec;
                error_power_d  = avg_err;
`endif
            end else begin
                acc_dec_d = sum_dec;
                acc_err_d = sum_err;
            end
        end
    end

    // Accumulator, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_dec_q      <= '0;
            acc_err_q      <= '0;
            cnt_q          <= '0;
            mapper_power_q <= '0;
            error_power_q  <= '0;
            power_valid_q  <= 1'b0;
        end else begin
            acc_dec_q      <= acc_dec_d;
            acc_err_q      <= acc_err_d;
            cnt_q          <= cnt_d;
            mapper_power_q <= mapper_power_d;
            error_power_q  <= error_power_d;
            power_valid_q  <= power_valid_d;
        end
    end

    assign mapper_power = mapper_power_q;
    assign error_power  = error_power_q;
    assign power_valid  = power_valid_q;

endmodule
